// File: rtl/picmicro_icsp_pkg.sv
// picmicro_icsp_pkg: shared opcodes, states and frame constants for the ICSP programmer
package picmicro_icsp_pkg;
  localparam int ICSP_CMD_BITS = 6;
  localparam int ICSP_FRAME_BITS = 16;
  localparam logic [13:0] ICSP_ERASE_VALUE = 14'h3FFF;
  localparam logic [5:0] OP_LOAD  = 6'h02;
  localparam logic [5:0] OP_READ  = 6'h04;
  localparam logic [5:0] OP_INC   = 6'h06;
  localparam logic [5:0] OP_PROG  = 6'h08;
  localparam logic [5:0] OP_ERASE = 6'h09;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_LOAD, S_RFETCH, S_READ, S_PROG, S_ERASE} state_e;
  function automatic state_e cmd_next(input logic [5:0] op);
    return op == OP_LOAD ? S_LOAD : op == OP_READ ? S_RFETCH : op == OP_PROG ? S_PROG :
           op == OP_ERASE ? S_ERASE : S_CMD;
  endfunction
endpackage

// File: rtl/picmicro_icsp_programmer_sync.sv
// icsp_input_sync: synchronizers and edge pulses for pgc, pgd_in and prog_mode
module icsp_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pgc,
  input  logic pgd_in,
  input  logic prog_mode,
  output logic pgc_s,
  output logic pgd_s,
  output logic mode_s,
  output logic pgc_rise,
  output logic pgc_fall,
  output logic mode_rise,
  output logic mode_fall
);
  logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
  logic [1:0] prev_q, prev_d;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], {prog_mode, pgd_in, pgc}};
    prev_d = {mode_s, pgc_s};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
  assign {mode_s, pgd_s, pgc_s} = sync_q[SYNC_STAGES-1];
  assign pgc_rise  = pgc_s & ~prev_q[0];
  assign pgc_fall  = ~pgc_s & prev_q[0];
  assign mode_rise = mode_s & ~prev_q[1];
  assign mode_fall = ~mode_s & prev_q[1];
endmodule

// File: rtl/picmicro_icsp_programmer.sv
// picmicro_icsp_programmer: ICSP slave writing/reading PIC16F program memory over PGC/PGD
module picmicro_icsp_programmer
  import picmicro_icsp_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PROG_CYCLES = 16,
  parameter int ADDR_WIDTH  = 13,
  parameter int DATA_WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_mode,
  input  logic                  pgc,
  input  logic                  pgd_in,
  output logic                  pgd_out,
  output logic                  pgd_oe,
  output logic                  core_hold,
  output logic [ADDR_WIDTH-1:0] pm_addr,
  output logic                  pm_wr_en,
  output logic [DATA_WIDTH-1:0] pm_wr_data,
  output logic                  pm_rd_en,
  input  logic [DATA_WIDTH-1:0] pm_rd_data
);
  localparam int FW = DATA_WIDTH + 2;
  localparam int PW = $clog2(PROG_CYCLES + 1);
  logic pgc_s, pgd_s, mode_s, pgc_rise, pgc_fall, mode_rise, mode_fall;
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, erase_cnt_q, erase_cnt_d;
  logic [DATA_WIDTH-1:0] latch_q, latch_d;
  logic [FW-1:0] shift_q, shift_d, shift_in;
  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic [PW-1:0] prog_cnt_q, prog_cnt_d;
  logic pgd_out_q, pgd_out_d;
  logic [5:0] cmd;
  icsp_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(rst), .pgc(pgc), .pgd_in(pgd_in), .prog_mode(prog_mode),
    .pgc_s(pgc_s), .pgd_s(pgd_s), .mode_s(mode_s), .pgc_rise(pgc_rise), .pgc_fall(pgc_fall),
    .mode_rise(mode_rise), .mode_fall(mode_fall)
  );
  // bits arrive LSb first, so each new bit enters at the top of the shifter
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    latch_d = latch_q;
    shift_d = shift_q;
    bit_cnt_d = bit_cnt_q;
    prog_cnt_d = '0;
    erase_cnt_d = '0;
    pgd_out_d = 1'b0;
    pm_wr_en = 1'b0;
    pm_wr_data = '0;
    pm_rd_en = 1'b0;
    shift_in = {pgd_s, shift_q[FW-1:1]};
    cmd = shift_in[FW-1 -: ICSP_CMD_BITS];
    if (mode_fall || !mode_s) begin
      state_d = S_IDLE;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (mode_rise) begin
          state_d = S_CMD;
          addr_d = '0;
          latch_d = DATA_WIDTH'(ICSP_ERASE_VALUE);
          bit_cnt_d = '0;
        end
        S_CMD: if (pgc_fall) begin
          shift_d = shift_in;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'(ICSP_CMD_BITS - 1)) begin
            bit_cnt_d = '0;
            addr_d = cmd == OP_INC ? addr_q + ADDR_WIDTH'(1) : addr_q;
            state_d = cmd_next(cmd);
          end
        end
        S_LOAD: if (pgc_fall) begin
          shift_d = shift_in;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'(ICSP_FRAME_BITS - 1)) begin
            bit_cnt_d = '0;
            latch_d = shift_in[DATA_WIDTH:1];
            state_d = S_CMD;
          end
        end
        S_RFETCH: begin
          pm_rd_en = bit_cnt_q == 5'd0;
          bit_cnt_d = 5'd1;
          if (bit_cnt_q[0]) begin
            shift_d = {1'b0, pm_rd_data, 1'b0};
            bit_cnt_d = '0;
            state_d = S_READ;
          end
        end
        S_READ: begin
          pgd_out_d = pgc_rise ? shift_q[0] : pgd_out_q;
          shift_d = pgc_rise ? shift_q >> 1 : shift_q;
          if (pgc_fall) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'(ICSP_FRAME_BITS - 1)) begin
              bit_cnt_d = '0;
              state_d = S_CMD;
            end
          end
        end
        S_PROG: begin
          prog_cnt_d = prog_cnt_q + PW'(1);
          if (prog_cnt_q == PW'(PROG_CYCLES)) begin
            pm_wr_en = 1'b1;
            pm_wr_data = latch_q;
            prog_cnt_d = '0;
            state_d = S_CMD;
          end
        end
        S_ERASE: begin
          pm_wr_en = 1'b1;
          pm_wr_data = DATA_WIDTH'(ICSP_ERASE_VALUE);
          erase_cnt_d = erase_cnt_q + ADDR_WIDTH'(1);
          state_d = &erase_cnt_q ? S_CMD : S_ERASE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      latch_q <= DATA_WIDTH'(ICSP_ERASE_VALUE);
      shift_q <= '0;
      bit_cnt_q <= '0;
      prog_cnt_q <= '0;
      erase_cnt_q <= '0;
      pgd_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      latch_q <= latch_d;
      shift_q <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      prog_cnt_q <= prog_cnt_d;
      erase_cnt_q <= erase_cnt_d;
      pgd_out_q <= pgd_out_d;
    end
  end
  // the erase sweep drives its own address; addr_q is untouched so it reappears afterwards
  assign pm_addr = state_q == S_ERASE ? erase_cnt_q : addr_q;
  assign pgd_out = pgd_out_q;
  assign pgd_oe = state_q == S_READ;
  assign core_hold = state_q != S_IDLE;
endmodule

// File: tb/tb_picmicro_icsp_programmer.sv
// tb_picmicro_icsp_programmer: scoreboard bench with a host driver and a reference memory/address model
module tb_picmicro_icsp_programmer;
  import picmicro_icsp_pkg::*;
  localparam int SS = 2, PC = 16, AW = 8, DW = 14, HALF = 6;
  logic clk = 0, rst = 1, prog_mode = 0, pgc = 0, pgd_in = 0;
  logic pgd_out, pgd_oe, core_hold, pm_wr_en, pm_rd_en;
  logic [AW-1:0] pm_addr;
  logic [DW-1:0] pm_wr_data, pm_rd_data;
  picmicro_icsp_programmer #(.SYNC_STAGES(SS), .PROG_CYCLES(PC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .prog_mode(prog_mode), .pgc(pgc), .pgd_in(pgd_in), .pgd_out(pgd_out),
    .pgd_oe(pgd_oe), .core_hold(core_hold), .pm_addr(pm_addr), .pm_wr_en(pm_wr_en),
    .pm_wr_data(pm_wr_data), .pm_rd_en(pm_rd_en), .pm_rd_data(pm_rd_data)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (pm_wr_en) mem[pm_addr] <= pm_wr_data;
    if (pm_rd_en) pm_rd_data <= mem[pm_addr];
  end
  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d; int lo; int hi;} wr_t;
  typedef struct {string n; int got; int exp;} pc_t;
  wr_t exp_wr[$];
  pc_t chk_q[$];
  logic [15:0] exp_rd[$], got_rd[$];
  int tests = 0, fails = 0, rd_cnt = 0, oe_len = 0, last_fall = 0;
  bit lax = 0, no_oe_chk = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_latch = 14'h3FFF;
  logic [DW-1:0] ref_mem [2**AW];
  wr_t e;
  pc_t p;
  logic [15:0] gr, er;
  always @(negedge clk) begin
    if (pm_wr_en && pm_rd_en) begin
      tests++; fails++;
      $display("FAIL wr_rd_overlap at cyc %0d", cyc);
    end
    if (pm_wr_en) begin
      tests++;
      if (lax) begin
        if (pm_wr_data !== 14'h3FFF) begin fails++; $display("FAIL abort_erase_data got %0h exp 3fff", pm_wr_data); end
      end else if (exp_wr.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write got addr %0h data %0h at cyc %0d, exp none", pm_addr, pm_wr_data, cyc);
      end else begin
        e = exp_wr.pop_front();
        if (pm_addr !== e.a || pm_wr_data !== e.d || cyc < e.lo || cyc > e.hi) begin
          fails++;
          $display("FAIL write got addr %0h data %0h cyc %0d, exp addr %0h data %0h cyc %0d..%0d",
                   pm_addr, pm_wr_data, cyc, e.a, e.d, e.lo, e.hi);
        end
      end
    end
    if (pm_rd_en) rd_cnt++;
    if (pgd_oe) oe_len++;
    else if (oe_len != 0) begin
      if (!no_oe_chk) begin
        tests++;
        if (oe_len < 32*HALF-4 || oe_len > 32*HALF) begin
          fails++; $display("FAIL oe_length got %0d exp about %0d", oe_len, 32*HALF-2);
        end
      end
      oe_len = 0;
    end
    while (got_rd.size() > 0 && exp_rd.size() > 0) begin
      gr = got_rd.pop_front(); er = exp_rd.pop_front(); tests++;
      if (gr !== er) begin fails++; $display("FAIL read_frame got %h exp %h", gr, er); end
    end
    while (chk_q.size() > 0) begin
      p = chk_q.pop_front(); tests++;
      if (p.got != p.exp) begin fails++; $display("FAIL %s got %0h exp %0h", p.n, p.got, p.exp); end
    end
  end
  task automatic tick(input int n); repeat (n) @(negedge clk); endtask
  task automatic probe(input string n, input int got, input int exp); chk_q.push_back('{n, got, exp}); endtask
  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      pgd_in = v[i]; pgc = 1; tick(HALF); pgc = 0; last_fall = cyc;
      if (i < n-1) tick(HALF);
    end
  endtask
  task automatic cmd(input logic [5:0] op); send_bits({10'd0, op}, 6); endtask
  task automatic load(input logic [DW-1:0] d);
    cmd(OP_LOAD); tick(HALF); send_bits({1'b1, d, 1'b1}, 16); tick(HALF); m_latch = d;
  endtask
  task automatic inc(); cmd(OP_INC); tick(HALF); m_addr = m_addr + 1'b1; endtask
  task automatic prog();
    cmd(OP_PROG);
    exp_wr.push_back('{m_addr, m_latch, last_fall + PC, last_fall + PC + SS + 4});
    ref_mem[m_addr] = m_latch;
    tick(PC + 4);
  endtask
  task automatic rd();
    logic [15:0] f;
    int n0 = rd_cnt;
    cmd(OP_READ);
    exp_rd.push_back({1'b0, ref_mem[m_addr], 1'b0});
    tick(HALF);
    for (int i = 0; i < 16; i++) begin
      pgc = 1; tick(HALF); f[i] = pgd_out; pgc = 0; tick(HALF);
    end
    got_rd.push_back(f);
    probe("rd_en_count", rd_cnt - n0, 1);
  endtask
  task automatic erase_all();
    cmd(OP_ERASE);
    for (int i = 0; i < 2**AW; i++) exp_wr.push_back('{AW'(i), 14'h3FFF, last_fall + i, last_fall + i + SS + 4});
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = 14'h3FFF;
    tick(HALF);
    repeat ((2**AW - 24) / (2*HALF)) begin pgd_in = 1'($urandom); pgc = 1; tick(HALF); pgc = 0; tick(HALF); end
    while (cyc < last_fall + 2**AW + 6) tick(1);
    probe("addr_restored", int'(pm_addr), int'(m_addr));
    tick(HALF);
  endtask
  task automatic drop();
    prog_mode = 0; tick(SS + 2);
    probe("core_hold_drop", int'(core_hold), 0);
    probe("pgd_oe_drop", int'(pgd_oe), 0);
  endtask
  task automatic enter();
    prog_mode = 1; tick(SS + 4); m_addr = '0; m_latch = 14'h3FFF;
    probe("core_hold_enter", int'(core_hold), 1);
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    logic [5:0] op;
    tick(3);
    probe("rst_core_hold", int'(core_hold), 0);
    probe("rst_pgd_oe", int'(pgd_oe), 0);
    probe("rst_pgd_out", int'(pgd_out), 0);
    probe("rst_wr_en", int'(pm_wr_en), 0);
    probe("rst_rd_en", int'(pm_rd_en), 0);
    probe("rst_wr_data", int'(pm_wr_data), 0);
    probe("rst_addr", int'(pm_addr), 0);
    rst = 0; tick(4);
    probe("idle_core_hold", int'(core_hold), 0);
    enter();
    load(14'h1234); prog(); rd();
    inc(); inc(); inc(); load(14'h0ABC); prog(); rd();
    cmd(6'h3F); tick(HALF); load(14'h0001); prog();
    inc(); cmd(OP_LOAD); tick(HALF); send_bits(16'h5555, 8); drop(); enter(); prog();
    load(14'($urandom)); cmd(OP_PROG); tick(5); drop(); tick(PC + 6); enter();
    cmd(OP_ERASE); lax = 1; tick(40); drop(); lax = 0; enter();
    repeat (5) inc();
    erase_all();
    drop(); enter(); load(14'h2A55); prog(); rd();
    repeat (2**AW) inc();
    load(14'h1555); prog(); rd();
    cmd(OP_READ); tick(HALF);
    repeat (5) begin pgc = 1; tick(HALF); pgc = 0; tick(HALF); end
    no_oe_chk = 1; pgc = 1; tick(2); rst = 1;
    @(posedge clk); #1;
    probe("pgd_oe_rst", int'(pgd_oe), 0);
    pgc = 0; tick(3); rst = 0; tick(SS + 4);
    m_addr = '0; m_latch = 14'h3FFF;
    probe("core_hold_after_rst", int'(core_hold), 1);
    no_oe_chk = 0;
    for (int k = 0; k < 50; k++) begin
      case ($urandom_range(0, 4))
        0: load(14'($urandom));
        1: inc();
        2: prog();
        3: rd();
        default: begin
          op = 6'($urandom);
          if (op inside {OP_LOAD, OP_READ, OP_INC, OP_PROG, OP_ERASE}) op = 6'h3F;
          cmd(op); tick(HALF);
        end
      endcase
    end
    tick(30);
    probe("pending_writes", exp_wr.size(), 0);
    probe("pending_reads", exp_rd.size(), 0);
    tick(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/picmicro_icsp_programmer.md
# picmicro_icsp_programmer

In-circuit serial programming (ICSP) slave for the PIC16F midrange core. It receives PIC-style serial commands on PGC/PGD and writes 14-bit instruction words into program memory. It also reads stored words back to the host. It is the write-side counterpart to the core's instruction-fetch read of `program_memory`, and it holds the core idle while programming is in progress.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flop stages on the `pgc`, `pgd_in` and `prog_mode` inputs.
- `PROG_CYCLES`, 16: number of clk cycles in the Begin Programming busy interval.
- `ADDR_WIDTH`, 13: program memory address width.
- `DATA_WIDTH`, 14: instruction word width.

Ports:
- `clk`  in  1  system clock; the only clock in the block.
- `rst`  in  1  synchronous, active-high reset.
- `prog_mode`  in  1  programming-mode enable (MCLR/VPP equivalent); asynchronous to `clk`, synchronized internally.
- `pgc`  in  1  host serial clock; asynchronous, synchronized internally.
- `pgd_in`  in  1  host serial data.
- `pgd_out`  out  1  device serial data, meaningful during read frames.
- `pgd_oe`  out  1  high while the device drives PGD.
- `core_hold`  out  1  holds the core in reset/stall.
- `pm_addr`  out  13  program memory address.
- `pm_wr_en`  out  1  one-cycle write strobe.
- `pm_wr_data`  out  14  write data.
- `pm_rd_en`  out  1  one-cycle read strobe. Read data is registered: `pm_rd_data` is valid on the cycle after the strobe.
- `pm_rd_data`  in  14  read data.

## Operation
- The synchronized `pgc` is edge-detected. `pgd_in` is sampled on each synchronized falling edge of `pgc`. Read-frame bits are driven on each synchronized rising edge.
- Command: 6 bits, LSb first. Supported opcodes:
  - 0x02: Load Data PM.
  - 0x04: Read Data PM.
  - 0x06: Increment Address.
  - 0x08: Begin Programming.
  - 0x09: Bulk Erase.
  - Any other opcode is ignored, and the block returns to CMD.
- Data frame: 16 bits, LSb first. Bit 0 is the start bit, bits 1–14 are data[0..13], bit 15 is the stop bit. Start and stop bits are ignored on load and driven as 0 on read.
- States:
  - IDLE: the synchronized `prog_mode` is low.
  - CMD: entered when the synchronized `prog_mode` rises. On entry, `pm_addr` is cleared to 0 and the data latch is set to 0x3FFF.
  - LOAD: after 0x02. Shifts in 16 bits, loads the 14 data bits into the latch, then returns to CMD.
  - RFETCH: after 0x04. Pulses `pm_rd_en` for 1 cycle, captures `pm_rd_data` on the next cycle, then goes to READ.
  - READ: shifts out 16 bits with `pgd_oe` high. `pgd_oe` drops on the falling edge that ends bit 15, and the block returns to CMD.
  - Increment Address (0x06): `pm_addr <= pm_addr + 1`, mod 2^13, so 0x1FFF wraps to 0x0000. Stays in CMD.
  - PROG: after 0x08. Busy for `PROG_CYCLES` cycles, then issues one `pm_wr_en` with the latch contents at `pm_addr`, then returns to CMD.
  - ERASE: after 0x09. Writes 0x3FFF to addresses 0x0000..0x1FFF in ascending order, one write per cycle, using an internal counter. `pm_addr` is restored to its pre-erase value afterwards. Then returns to CMD.
- `pgc` edges are ignored during PROG, ERASE and RFETCH.
- `core_hold` is high whenever state ≠ IDLE.
- If the synchronized `prog_mode` falls in any state, the block goes to IDLE on the next cycle. A partial frame is discarded, a pending or in-progress write is abandoned (no further `pm_wr_en`), and `pgd_oe` goes to 0.

## Timing
- Reset values:
  - State: IDLE.
  - `pm_addr`: 0.
  - Data latch: 0x3FFF.
  - `pgd_out`, `pgd_oe`, `core_hold`, `pm_wr_en`, `pm_rd_en`, `pm_wr_data`: all 0.
- Input latency: a `pgc` edge is acted on `SYNC_STAGES` + 1 cycles after it occurs.
- Host constraint: each `pgc` half-period is at least `SYNC_STAGES` + 3 clk cycles.
- Host constraint: after a 0x08 command, the host waits at least `PROG_CYCLES` + 2 cycles before the next command.
- Host constraint: after a 0x09 command, the host waits at least 8192 + 2 cycles before the next command.
- RFETCH completes within 2 cycles, before the first read-bit rising edge.
- `pm_wr_data` is valid on the same cycle as `pm_wr_en`.
- `pm_wr_en` and `pm_rd_en` are never asserted together.

## Structure
- Package `picmicro_icsp_pkg` holds:
  - the command opcode constants;
  - the state enum;
  - `ICSP_CMD_BITS` = 6;
  - `ICSP_FRAME_BITS` = 16;
  - `ICSP_ERASE_VALUE` = 14'h3FFF.
- Sub-module `icsp_input_sync` contains:
  - the `SYNC_STAGES` synchronizers for `pgc`, `pgd_in` and `prog_mode`;
  - rise/fall pulse outputs for `pgc` and `prog_mode`.

## Test plan
- Enter `prog_mode`, send 0x02 + data 0x1234, then 0x08. Required: `core_hold` = 1, and exactly one `pm_wr_en`, `PROG_CYCLES` cycles after the command, with addr 0x0000 and data 0x1234.
- Send 0x06 three times, then load 0x0ABC and program. Required: the write lands at addr 0x0003. Send 8192 increments from 0, then program. Required: the write lands at 0x0000 (wrap).
- Memory model holds 0x2A55 at addr 0; send 0x04. Required: one `pm_rd_en`, then `pgd_out` bits 0, 0x2A55 LSb first, 0. `pgd_oe` is high for exactly 16 bit periods.
- Send 0x09. Required: 8192 consecutive `pm_wr_en` pulses with data 0x3FFF and addr 0x0000→0x1FFF. `pgc` toggling during the erase has no effect, and `pm_addr` is restored afterwards.
- Send an unknown opcode 0x3F, then a valid load+program of 0x0001. Required: only one write, of 0x0001.
- Drop `prog_mode` mid-LOAD, mid-PROG and mid-ERASE. Required: no further `pm_wr_en`, IDLE with `core_hold` = 0 within `SYNC_STAGES` + 2 cycles. On re-entry, the address is 0 and the latch is 0x3FFF. Assert `rst` mid-READ: `pgd_oe` = 0 on the next cycle.
